// File: rtl/alu_pkg.sv
// Shared constants, FSM state and instruction payload for the ALU issue controller.
package alu_pkg;

    localparam int unsigned DW   = 16;
    localparam int unsigned NREG = 8;
    localparam int unsigned AW   = 3;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_SLT = 4'b0111;

    localparam int unsigned NFLG     = 5;
    localparam int unsigned FLG_COUT = 4;
    localparam int unsigned FLG_LT   = 3;
    localparam int unsigned FLG_EQ   = 2;
    localparam int unsigned FLG_GT   = 1;
    localparam int unsigned FLG_OVF  = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OPER = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0]    op;
        logic [AW-1:0] rd;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic          imm_en;
        logic [DW-1:0] imm;
    } instr_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREG x DW register file: one synchronous write port, two operand reads and a
// debug read, all combinational; register 0 always reads as zero.
module alu_regfile
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    logic [DW-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a  = (raddr_a  == '0) ? '0 : regs[raddr_a];
    assign rdata_b  = (raddr_b  == '0) ? '0 : regs[raddr_b];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 16-bit combinational ALU: accept, read operands, execute, write back.
// Optional retired-instruction counter enabled by defining ALU_ISSUE_CNT_EN.
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [3:0]      instr_op,
    input  logic [AW-1:0]   instr_rd,
    input  logic [AW-1:0]   instr_rs,
    input  logic [AW-1:0]   instr_rt,
    input  logic            instr_imm_en,
    input  logic [DW-1:0]   instr_imm,
    output logic [DW-1:0]   alu_x,
    output logic [DW-1:0]   alu_y,
    output logic [3:0]      alu_c,
    input  logic [DW-1:0]   alu_z,
    input  logic            alu_c_out,
    input  logic            alu_lt,
    input  logic            alu_eq,
    input  logic            alu_gt,
    input  logic            alu_overflow,
    output logic            done,
    output logic            illegal,
    output logic [NFLG-1:0] flags,
    input  logic [AW-1:0]   dbg_addr,
    output logic [DW-1:0]   dbg_data
`ifdef ALU_ISSUE_CNT_EN
    ,
    output logic [15:0]     retired_cnt
`endif
);

    state_t          state_q;
    state_t          state_d;
    instr_t          instr_q;
    logic [DW-1:0]   z_hold;
    logic [NFLG-1:0] st_hold;
    logic [DW-1:0]   rdata_x;
    logic [DW-1:0]   rdata_y;
    logic            accept;
    logic            legal;
    logic            wb_we;

    assign instr_ready = (state_q == S_IDLE) && !rst;
    assign accept      = instr_valid && instr_ready;
    assign legal       = op_is_legal(instr_q.op);
    assign wb_we       = (state_q == S_WB) && legal;

    alu_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (wb_we),
        .waddr    (instr_q.rd),
        .wdata    (z_hold),
        .raddr_a  (instr_q.rs),
        .rdata_a  (rdata_x),
        .raddr_b  (instr_q.rt),
        .rdata_b  (rdata_y),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_OPER;
            S_OPER: state_d = S_EXEC;
            S_EXEC: state_d = S_WB;
            S_WB:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers; done/illegal are launched at the end of EXEC so they are high during WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= '0;
            alu_x   <= '0;
            alu_y   <= '0;
            alu_c   <= '0;
            z_hold  <= '0;
            st_hold <= '0;
            flags   <= '0;
            done    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            done    <= (state_q == S_EXEC);
            illegal <= (state_q == S_EXEC) && !legal;
            if (accept) begin
                instr_q <= '{op: instr_op, rd: instr_rd, rs: instr_rs, rt: instr_rt,
                             imm_en: instr_imm_en, imm: instr_imm};
            end
            if (state_q == S_OPER) begin
                alu_x <= rdata_x;
                alu_y <= instr_q.imm_en ? instr_q.imm : rdata_y;
                alu_c <= instr_q.op;
            end
            if (state_q == S_EXEC) begin
                z_hold            <= alu_z;
                st_hold[FLG_COUT] <= alu_c_out;
                st_hold[FLG_LT]   <= alu_lt;
                st_hold[FLG_EQ]   <= alu_eq;
                st_hold[FLG_GT]   <= alu_gt;
                st_hold[FLG_OVF]  <= alu_overflow;
            end
            if (wb_we) begin
                flags <= st_hold;
            end
        end
    end

`ifdef ALU_ISSUE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt <= '0;
        end else if (done) begin
            retired_cnt <= retired_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed table-driven bench for alu_issue_ctrl with a behavioural ALU attached.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  instr_op;
    logic [2:0]  instr_rd, instr_rs, instr_rt;
    logic        instr_imm_en;
    logic [15:0] instr_imm;
    logic [15:0] alu_x, alu_y, alu_z;
    logic [3:0]  alu_c;
    logic        alu_c_out, alu_lt, alu_eq, alu_gt, alu_overflow;
    logic        done, illegal;
    logic [4:0]  flags;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;
`ifdef ALU_ISSUE_CNT_EN
    logic [15:0] retired_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_op     (instr_op),
        .instr_rd     (instr_rd),
        .instr_rs     (instr_rs),
        .instr_rt     (instr_rt),
        .instr_imm_en (instr_imm_en),
        .instr_imm    (instr_imm),
        .alu_x        (alu_x),
        .alu_y        (alu_y),
        .alu_c        (alu_c),
        .alu_z        (alu_z),
        .alu_c_out    (alu_c_out),
        .alu_lt       (alu_lt),
        .alu_eq       (alu_eq),
        .alu_gt       (alu_gt),
        .alu_overflow (alu_overflow),
        .done         (done),
        .illegal      (illegal),
        .flags        (flags),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
`ifdef ALU_ISSUE_CNT_EN
        ,
        .retired_cnt  (retired_cnt)
`endif
    );

    // Behavioural ALU: c_out is carry for ADD, borrow for SUB; unsupported ops give DEAD and odd flags.
    always_comb begin
        logic [16:0] sum;
        sum          = {1'b0, alu_x} + {1'b0, alu_y};
        alu_z        = 16'hDEAD;
        alu_c_out    = 1'b0;
        alu_overflow = 1'b0;
        alu_lt       = alu_x < alu_y;
        alu_eq       = alu_x == alu_y;
        alu_gt       = alu_x > alu_y;
        case (alu_c)
            4'b0000: alu_z = alu_x & alu_y;
            4'b0001: alu_z = alu_x | alu_y;
            4'b0010: begin
                alu_z        = sum[15:0];
                alu_c_out    = sum[16];
                alu_overflow = (alu_x[15] == alu_y[15]) && (sum[15] != alu_x[15]);
            end
            4'b0011: begin
                alu_z        = alu_x - alu_y;
                alu_c_out    = alu_x < alu_y;
                alu_overflow = (alu_x[15] != alu_y[15]) && (alu_z[15] != alu_x[15]);
            end
            4'b0111: alu_z = (alu_x < alu_y) ? 16'h0001 : 16'h0000;
            default: begin
                alu_c_out    = 1'b1;
                alu_overflow = 1'b1;
            end
        endcase
    end

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  rd, rs, rt;
        logic        imm_en;
        logic [15:0] imm;
        logic [15:0] exp_val;
        logic        exp_ill;
        logic [4:0]  exp_flags;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        instr_op     = v.op;
        instr_rd     = v.rd;
        instr_rs     = v.rs;
        instr_rt     = v.rt;
        instr_imm_en = v.imm_en;
        instr_imm    = v.imm;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int n;
        @(negedge clk);
        drive(v);
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("v%0d ready", idx), 32'(instr_ready), 32'd1);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d oper_done", idx), 32'(done), 32'd0);
        @(negedge clk);
        check($sformatf("v%0d exec_alu_c", idx), 32'(alu_c), 32'(v.op));
        check($sformatf("v%0d exec_ready", idx), 32'(instr_ready), 32'd0);
        @(negedge clk);
        check($sformatf("v%0d wb_done", idx), 32'(done), 32'd1);
        check($sformatf("v%0d wb_illegal", idx), 32'(illegal), 32'(v.exp_ill));
        dbg_addr = v.rd;
        @(negedge clk);
        check($sformatf("v%0d result", idx), 32'(dbg_data), 32'(v.exp_val));
        check($sformatf("v%0d flags", idx), 32'(flags), 32'(v.exp_flags));
        check($sformatf("v%0d done_low", idx), 32'(done), 32'd0);
    endtask

    initial begin
        logic [15:0] final_regs [8];
        vec_t bp [3];

        //           op       rd    rs    rt    ie    imm       exp       ill   flags
        vecs[0]  = '{4'b0010, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0005, 16'h0005, 1'b0, 5'b01000};
        vecs[1]  = '{4'b0010, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0003, 16'h0003, 1'b0, 5'b01000};
        vecs[2]  = '{4'b0011, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000, 16'h0002, 1'b0, 5'b00010};
        vecs[3]  = '{4'b0000, 3'd4, 3'd1, 3'd0, 1'b1, 16'h0006, 16'h0004, 1'b0, 5'b01000};
        vecs[4]  = '{4'b0001, 3'd5, 3'd1, 3'd2, 1'b0, 16'h0000, 16'h0007, 1'b0, 5'b00010};
        vecs[5]  = '{4'b0111, 3'd6, 3'd2, 3'd1, 1'b0, 16'h0000, 16'h0001, 1'b0, 5'b01000};
        vecs[6]  = '{4'b0111, 3'd6, 3'd1, 3'd2, 1'b0, 16'h0000, 16'h0000, 1'b0, 5'b00010};
        vecs[7]  = '{4'b0010, 3'd7, 3'd0, 3'd0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 5'b01000};
        vecs[8]  = '{4'b0010, 3'd7, 3'd7, 3'd0, 1'b1, 16'h0001, 16'h0000, 1'b0, 5'b10010};
        vecs[9]  = '{4'b0011, 3'd1, 3'd1, 3'd1, 1'b0, 16'h0000, 16'h0000, 1'b0, 5'b00100};
        vecs[10] = '{4'b0010, 3'd0, 3'd2, 3'd0, 1'b1, 16'h0001, 16'h0000, 1'b0, 5'b00010};
        vecs[11] = '{4'b0101, 3'd2, 3'd3, 3'd5, 1'b0, 16'h0000, 16'h0003, 1'b1, 5'b00010};
        vecs[12] = '{4'b0010, 3'd3, 3'd2, 3'd0, 1'b1, 16'h7FFF, 16'h8002, 1'b0, 5'b01001};
        vecs[13] = '{4'b0011, 3'd4, 3'd0, 3'd2, 1'b0, 16'h0000, 16'hFFFD, 1'b0, 5'b11000};
        final_regs = '{16'h0000, 16'h0000, 16'h0003, 16'h8002, 16'hFFFD, 16'h0007, 16'h0000, 16'h0000};
        bp[0] = '{4'b0010, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0011, 16'h0011, 1'b0, 5'b01000};
        bp[1] = '{4'b0010, 3'd2, 3'd1, 3'd0, 1'b1, 16'h0022, 16'h0033, 1'b0, 5'b01000};
        bp[2] = '{4'b0001, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000, 16'h0033, 1'b0, 5'b01000};

        // Reset with a junk instruction offered; it must be ignored.
        rst = 1'b1;
        instr_valid = 1'b1;
        drive('{4'b0010, 3'd5, 3'd0, 3'd0, 1'b1, 16'h1234, 16'h0, 1'b0, 5'b0});
        dbg_addr = 3'd5;
        repeat (2) begin
            @(negedge clk);
            check("rst ready", 32'(instr_ready), 32'd0);
            check("rst done", 32'(done), 32'd0);
        end
        check("rst flags", 32'(flags), 32'd0);
        check("rst alu_c", 32'(alu_c), 32'd0);
        rst = 1'b0;
        instr_valid = 1'b0;
        #1 check("post-rst ready", 32'(instr_ready), 32'd1);
        repeat (4) @(negedge clk);
        check("post-rst no done", 32'(done), 32'd0);
        check("post-rst r5", 32'(dbg_data), 32'd0);

        for (int i = 0; i < 14; i++) begin
            run_vec(i, vecs[i]);
        end

        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1 check($sformatf("final r%0d", i), 32'(dbg_data), 32'(final_regs[i]));
        end
`ifdef ALU_ISSUE_CNT_EN
        check("cnt after table", 32'(retired_cnt), 32'd14);
`endif

        // Backpressure: valid held high, three back-to-back instructions.
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            drive(bp[k / 4]);
            instr_valid = 1'b1;
            check($sformatf("bp ready k%0d", k), 32'(instr_ready), 32'((k % 4) == 0));
            check($sformatf("bp done k%0d", k), 32'(done), 32'((k % 4) == 3));
        end
        @(negedge clk);
        instr_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dbg_addr = bp[i].rd;
            #1 check($sformatf("bp r%0d", bp[i].rd), 32'(dbg_data), 32'(bp[i].exp_val));
        end
`ifdef ALU_ISSUE_CNT_EN
        check("cnt after bp", 32'(retired_cnt), 32'd17);
`endif

        // Reset asserted while the instruction is in EXEC.
        @(negedge clk);
        drive('{4'b0010, 3'd6, 3'd0, 3'd0, 1'b1, 16'h0042, 16'h0, 1'b0, 5'b0});
        instr_valid = 1'b1;
        check("rexec ready", 32'(instr_ready), 32'd1);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rexec in exec", 32'(alu_c), 32'h2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 check("rexec idle", 32'(instr_ready), 32'd1);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("rexec no done c%0d", c), 32'(done), 32'd0);
            @(negedge clk);
        end
        dbg_addr = 3'd6;
        #1 check("rexec r6", 32'(dbg_data), 32'd0);
        dbg_addr = 3'd1;
        #1 check("rexec r1 cleared", 32'(dbg_data), 32'd0);
        check("rexec flags", 32'(flags), 32'd0);
`ifdef ALU_ISSUE_CNT_EN
        check("rexec cnt", 32'(retired_cnt), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
